// File: rtl/input_cond_pkg.sv
// Shared types and sizing for the switch input conditioner.
package input_cond_pkg;

  typedef enum logic {DB_IDLE, DB_CHECK} db_state_t;

  localparam int N_INPUTS = 3;

endpackage

// File: rtl/debounce_bit.sv
// One switch lane: 2-FF synchroniser followed by a persistence-checking debounce FSM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DB_IDLE  | synchronised input matches level, cnt held at 0
// DB_CHECK | input differs from level, cnt counts persistence cycles
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int CNT_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic update
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          s1;
  logic          s2;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // Acceptance is decoded combinationally so the top can register the strobe
  // on the same edge that moves level.
  assign update = (state == DB_CHECK) && (s2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      state <= DB_IDLE;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      case (state)
        DB_IDLE: begin
          cnt <= '0;
          if (s2 != level) state <= DB_CHECK;
        end
        DB_CHECK: begin
          if (s2 == level) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            level <= s2;
            state <= DB_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions three raw switches into debounced levels plus a registered change strobe and mask.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int CNT_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw0,
  input  logic       sw1,
  input  logic       sw2,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       changed,
  output logic [2:0] changed_mask
);

  logic [N_INPUTS-1:0] raw;
  logic [N_INPUTS-1:0] level;
  logic [N_INPUTS-1:0] update;

  assign raw = {sw2, sw1, sw0};

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
    debounce_bit #(.CNT_MAX(CNT_MAX)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[i]),
      .level  (level[i]),
      .update (update[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed      <= 1'b0;
      changed_mask <= '0;
    end else begin
      changed      <= |update;
      changed_mask <= update;
    end
  end

  assign x0 = level[0];
  assign x1 = level[1];
  assign x2 = level[2];

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage for the three-input logic network. It takes the raw, asynchronous switch inputs `sw0..sw2` and delivers clean, synchronised and debounced levels `x0..x2`, which drive the downstream combinational block's `x0..x2` inputs directly. It also produces a one-cycle change strobe and a per-bit mask, so a consumer can capture the downstream `y0/y1` once per accepted input change.

## Interface
- `CNT_MAX`, default 4, is the number of consecutive CHECK cycles a new level must persist before it is accepted. Legal range is ≥ 1.
- `clk`  in  1  is the single clock. All state changes on the rising edge.
- `rst`  in  1  is the reset. It is asynchronous and active-high.
- `sw0`  in  1  is the raw switch input, asynchronous to `clk`.
- `sw1`  in  1  is the raw switch input, asynchronous to `clk`.
- `sw2`  in  1  is the raw switch input, asynchronous to `clk`.
- `x0`  out  1  is the debounced level of `sw0`, registered.
- `x1`  out  1  is the debounced level of `sw1`, registered.
- `x2`  out  1  is the debounced level of `sw2`, registered.
- `changed`  out  1  is a one-cycle pulse asserted in the cycle in which any `x*` has just changed.
- `changed_mask`  out  3  flags which bits changed in that cycle (bit i corresponds to `xi`). It is 0 whenever `changed` = 0.

## Operation
- Each bit runs independently through the same pipeline: a 2-FF synchroniser (`s1` → `s2`), then a debounce FSM with counter `cnt`. Counter width is `$clog2(CNT_MAX)`, minimum 1.
- FSM states:
  - DB_IDLE: `cnt` is held at 0.
    - If `s2 != x`, go to DB_CHECK with `cnt = 0`.
    - Otherwise stay.
  - DB_CHECK:
    - If `s2 == x`, the change is a glitch: go to DB_IDLE and set `cnt = 0`.
    - Else if `cnt == CNT_MAX-1`: set `x <= s2`, assert this bit's update, go to DB_IDLE, set `cnt = 0`.
    - Otherwise `cnt++`.
- `changed` is the registered OR of the three per-bit updates. `changed_mask` is the registered vector of those updates. Both are registered in the same edge that updates `x`.
- Reset values: `s1 = s2 = 0`, `x0 = x1 = x2 = 0`, `changed = 0`, `changed_mask = 0`, all FSMs in DB_IDLE, `cnt = 0`.
- Simultaneous acceptance on several bits produces one `changed` pulse with several mask bits set.
- The counter never wraps. It is bounded by `CNT_MAX-1`.

## Timing
- Latency: let edge 0 be the first edge that samples the new `sw` level into `s1`. If the level stays stable, `x` and `changed` update at edge `CNT_MAX+2`. With the default, that is edge 6.
- Acceptance threshold:
  - A raw pulse seen in ≤ `CNT_MAX` consecutive samples is rejected; `x` and `changed` do not move.
  - A pulse seen in ≥ `CNT_MAX+1` consecutive samples is accepted.
- `changed` is high for exactly one cycle per acceptance. Back-to-back acceptances are impossible on one bit; they are at least `CNT_MAX+1` cycles apart.
- Reset asserted at any time, including mid-DB_CHECK, forces all reset values immediately and without waiting for `clk`.
- After reset is released, a `sw` held at 1 appears on `x` at edge `CNT_MAX+2`, counted from the first edge after release.
- All outputs come straight from flops. There is no combinational path from `sw*` to any output.

## Structure
- Shared package `input_cond_pkg`:
  - `typedef enum logic {DB_IDLE, DB_CHECK} db_state_t`
  - `localparam int N_INPUTS = 3`
- Sub-module `debounce_bit`:
  - Parameter: `CNT_MAX`.
  - Ports: `clk`, `rst`, `raw`, `level`, `update`.
  - Contains the synchroniser, the FSM and the counter.
- The top level instantiates `debounce_bit` `N_INPUTS` times and registers `changed` and `changed_mask` from the update signals.

## Test plan
- **Reset:** assert `rst` with all `sw` = 1 → `x0..x2` = 0 and `changed` = 0 throughout reset. After release, `x0..x2` become 1 at edge 6 with `changed_mask = 3'b111` for one cycle.
- **Clean step (`CNT_MAX` = 4):** `sw0` goes 0→1 and is held → `x0` = 1 at edge 6, `changed` = 1 and `changed_mask = 3'b001` for exactly one cycle, `x1`/`x2` unchanged.
- **Glitch rejection:** `sw1` high for 4 samples then low → no change on `x1`, `changed` stays 0. Repeat with 5 samples → `x1` rises at edge 6, then falls 6 edges after the falling sample, with two separate `changed` pulses.
- **Bounce:** `sw2` toggles 1,0,1,1,0,1 then holds 1 → exactly one `x2` rise, occurring 6 edges after the final 0→1 sample.
- **Simultaneous change:** `sw0` and `sw2` rise on the same edge → a single `changed` pulse with `changed_mask = 3'b101`.
- **Reset mid-check:** raise `sw1`, assert `rst` at edge 4 (in DB_CHECK) → `x1` stays 0 and `cnt` clears. After release with `sw1` still 1, `x1` rises at edge 6 counted from release.
